// File: rtl/fmap_pkg.sv
// Shared widths, FSM encoding and address helper for the feature-map line reader.
package fmap_pkg;

  localparam int LINE_W   = 512;
  localparam int ADDR_W   = 64;
  localparam int HEIGHT_W = 9;
  localparam int STRIDE_W = 16;

  localparam logic [HEIGHT_W-1:0] HEIGHT_ZERO = 9'd0;
  localparam logic [HEIGHT_W-1:0] HEIGHT_ONE  = 9'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Next line address as a running sum; wraps modulo 2^64.
  function automatic logic [ADDR_W-1:0] next_line_addr(
    input logic [ADDR_W-1:0]   addr,
    input logic [STRIDE_W-1:0] stride
  );
    return addr + {{(ADDR_W-STRIDE_W){1'b0}}, stride};
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Show-ahead FIFO of full feature-map lines; push and pop may coincide when full.
module line_fifo #(
  parameter int Width = 512,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);
  localparam logic [PtrW:0] CntZero  = {(PtrW+1){1'b0}};
  localparam logic [PtrW:0] CntOne   = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW-1:0] PtrOne = {{(PtrW-1){1'b0}}, 1'b1};

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [PtrW:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CntZero);
  assign full      = (count_r == DepthCnt);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Line storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= CntZero;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CntOne;
        2'b01:   count_r <= count_r - CntOne;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fmap_line_reader.sv
// Fetches Height feature-map lines over an Avalon-MM read master, buffers them
// and broadcasts them on the shared input-feature bus under Halt backpressure.
module fmap_line_reader
  import fmap_pkg::*;
#(
  parameter int                FifoDepth   = 4,
  parameter logic [ADDR_W-1:0] DefaultBase = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Start_i,
  input  logic [ADDR_W-1:0]   BaseAddr_i,
  input  logic [STRIDE_W-1:0] Stride_i,
  input  logic [HEIGHT_W-1:0] Height_i,
  output logic                Busy_o,
  output logic                Done_o,
  output logic [ADDR_W-1:0]   AvalonAddr_o,
  output logic                AvalonRead_o,
  input  logic [LINE_W-1:0]   AvalonReadData_i,
  input  logic                AvalonWaitReq_i,
  output logic                AvalonLock_o,
  output logic                ShareValid_o,
  output logic [LINE_W-1:0]   ShareLine_o,
  output logic                ShareFirst_o,
  output logic                ShareLast_o,
  input  logic                Halt_i
);

  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FifoDepth);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [STRIDE_W-1:0] stride_r;
  logic [HEIGHT_W-1:0] height_r;
  logic [HEIGHT_W-1:0] issue_cnt_r;
  logic [HEIGHT_W-1:0] emit_cnt_r;

  logic                start_ok_s;
  logic                read_s;
  logic                push_s;
  logic                pop_s;
  logic                last_issue_s;

  logic [LINE_W-1:0]   fifo_data_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CntW-1:0]     fifo_count_s;

  logic                share_valid_r;
  logic                share_first_r;
  logic                share_last_r;
  logic [LINE_W-1:0]   share_line_r;

  line_fifo #(
    .Width (LINE_W),
    .Depth (FifoDepth)
  ) u_line_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (AvalonReadData_i),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Read request depends only on registered state and occupancy, so it holds across waitreq.
  assign read_s       = (state_r == READ) && (fifo_count_s < DepthCnt);
  assign push_s       = read_s && !AvalonWaitReq_i && !fifo_full_s;
  assign pop_s        = !fifo_empty_s && !Halt_i;
  assign last_issue_s = (issue_cnt_r == (height_r - HEIGHT_ONE));

  // Next-state decode and Start acceptance.
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start_i) begin
          start_ok_s = 1'b1;
          state_s    = (Height_i == HEIGHT_ZERO) ? FIN : READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (push_s && last_issue_s) begin
          state_s = DRAIN;
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        if (emit_cnt_r == height_r) begin
          state_s = FIN;
        end else begin
          state_s = DRAIN;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Frame state: operands, running address and issue/emit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      stride_r    <= {STRIDE_W{1'b0}};
      height_r    <= HEIGHT_ZERO;
      issue_cnt_r <= HEIGHT_ZERO;
      emit_cnt_r  <= HEIGHT_ZERO;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        addr_r      <= (BaseAddr_i == {ADDR_W{1'b0}}) ? DefaultBase : BaseAddr_i;
        stride_r    <= Stride_i;
        height_r    <= Height_i;
        issue_cnt_r <= HEIGHT_ZERO;
        emit_cnt_r  <= HEIGHT_ZERO;
      end else begin
        if (push_s) begin
          addr_r      <= next_line_addr(addr_r, stride_r);
          issue_cnt_r <= issue_cnt_r + HEIGHT_ONE;
        end
        if (pop_s) begin
          emit_cnt_r <= emit_cnt_r + HEIGHT_ONE;
        end
      end
    end
  end

  // Share-bus output stage; the line register keeps its value between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      share_valid_r <= 1'b0;
      share_first_r <= 1'b0;
      share_last_r  <= 1'b0;
      share_line_r  <= {LINE_W{1'b0}};
    end else begin
      share_valid_r <= pop_s;
      share_first_r <= pop_s && (emit_cnt_r == HEIGHT_ZERO);
      share_last_r  <= pop_s && (emit_cnt_r == (height_r - HEIGHT_ONE));
      if (pop_s) begin
        share_line_r <= fifo_data_s;
      end
    end
  end

  assign Busy_o       = (state_r == READ) || (state_r == DRAIN);
  assign Done_o       = (state_r == FIN);
  assign AvalonAddr_o = addr_r;
  assign AvalonRead_o = read_s;
  assign AvalonLock_o = 1'b0;
  assign ShareValid_o = share_valid_r;
  assign ShareLine_o  = share_line_r;
  assign ShareFirst_o = share_first_r;
  assign ShareLast_o  = share_last_r;

endmodule

// File: tb/tb_fmap_line_reader.sv
// Randomized bench for fmap_line_reader: an Avalon slave model with stalls and a
// line-list reference model check every read, share-bus beat and Done pulse.
module tb_fmap_line_reader;

  localparam logic [63:0] DEF_BASE = 64'h0000_0000_0008_0000;

  logic         clk;
  logic         rst;
  logic         Start_i;
  logic [63:0]  BaseAddr_i;
  logic [15:0]  Stride_i;
  logic [8:0]   Height_i;
  logic         Busy_o;
  logic         Done_o;
  logic [63:0]  AvalonAddr_o;
  logic         AvalonRead_o;
  logic [511:0] AvalonReadData_i;
  logic         AvalonWaitReq_i;
  logic         AvalonLock_o;
  logic         ShareValid_o;
  logic [511:0] ShareLine_o;
  logic         ShareFirst_o;
  logic         ShareLast_o;
  logic         Halt_i;

  fmap_line_reader #(
    .FifoDepth   (4),
    .DefaultBase (DEF_BASE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Start_i          (Start_i),
    .BaseAddr_i       (BaseAddr_i),
    .Stride_i         (Stride_i),
    .Height_i         (Height_i),
    .Busy_o           (Busy_o),
    .Done_o           (Done_o),
    .AvalonAddr_o     (AvalonAddr_o),
    .AvalonRead_o     (AvalonRead_o),
    .AvalonReadData_i (AvalonReadData_i),
    .AvalonWaitReq_i  (AvalonWaitReq_i),
    .AvalonLock_o     (AvalonLock_o),
    .ShareValid_o     (ShareValid_o),
    .ShareLine_o      (ShareLine_o),
    .ShareFirst_o     (ShareFirst_o),
    .ShareLast_o      (ShareLast_o),
    .Halt_i           (Halt_i)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [63:0]  exp_base = 64'd0;
  logic [15:0]  exp_stride = 16'd0;
  int           exp_h = 0;
  int           rd_idx = 0;
  int           em_idx = 0;
  int           start_cyc = 0;
  bit           frame_active = 1'b0;
  bit           done_seen = 1'b0;
  bit           rand_stall = 1'b0;
  bit           rand_halt = 1'b0;
  bit           halt_force = 1'b0;
  int           stall_len = 0;

  bit           prev_wait = 1'b0;
  bit           prev_last = 1'b0;
  bit           have_stall = 1'b0;
  logic [63:0]  prev_addr = 64'd0;
  logic [511:0] last_line = 512'd0;
  int           stall_cnt = 0;
  int           cur_stall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the byte address.
  function automatic logic [511:0] line_of(input logic [63:0] addr);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*64 +: 64] = addr * 64'h9E37_79B9_7F4A_7C15 + 64'(i) * 64'h0123_4567_89AB_CDEF;
    end
    return r;
  endfunction

  function automatic logic [63:0] line_addr(input int k);
    return exp_base + 64'(k) * {48'd0, exp_stride};
  endfunction

  // Avalon slave, halt driver and share-bus/Done checker, all on the falling edge.
  initial begin : slave_and_monitor
    AvalonWaitReq_i  = 1'b0;
    AvalonReadData_i = 512'd0;
    Halt_i           = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        prev_last = 1'b0;
        have_stall = 1'b0;
        last_line = 512'd0;
        AvalonWaitReq_i = 1'b0;
        Halt_i = 1'b0;
      end else begin
        if (prev_wait) begin
          check_eq("rd_hold", AvalonRead_o, 1'b1);
          check_eq("addr_hold", AvalonAddr_o, prev_addr);
        end
        if (AvalonRead_o) begin
          if (!have_stall) begin
            cur_stall = rand_stall ? int'($urandom_range(0, 2)) : stall_len;
            stall_cnt = 0;
            have_stall = 1'b1;
          end
          AvalonWaitReq_i = (stall_cnt < cur_stall);
          if (AvalonWaitReq_i) stall_cnt = stall_cnt + 1;
          else have_stall = 1'b0;
          AvalonReadData_i = line_of(AvalonAddr_o);
          if (!AvalonWaitReq_i) begin
            check_eq("rd_in_frame", frame_active && (rd_idx < exp_h), 1'b1);
            check_eq("rd_addr", AvalonAddr_o, line_addr(rd_idx));
            rd_idx = rd_idx + 1;
          end
        end else begin
          AvalonWaitReq_i = 1'($urandom_range(0, 1));
        end
        prev_wait = AvalonRead_o && AvalonWaitReq_i;
        prev_addr = AvalonAddr_o;

        if (Halt_i) check_eq("halt_quiet", ShareValid_o, 1'b0);
        if (ShareValid_o) begin
          check_eq("sh_in_frame", frame_active && (em_idx < exp_h), 1'b1);
          check_eq("sh_line", ShareLine_o, line_of(line_addr(em_idx)));
          check_eq("sh_first", ShareFirst_o, em_idx == 0);
          check_eq("sh_last", ShareLast_o, em_idx == exp_h - 1);
          last_line = line_of(line_addr(em_idx));
          em_idx = em_idx + 1;
        end else begin
          check_eq("idle_flags", {ShareFirst_o, ShareLast_o}, 2'b00);
          check_eq("line_hold", ShareLine_o, last_line);
        end

        if (Done_o) begin
          check_eq("done_in_frame", frame_active, 1'b1);
          check_eq("done_after_last", prev_last, exp_h != 0);
          check_eq("done_reads", rd_idx, exp_h);
          check_eq("done_emits", em_idx, exp_h);
          check_eq("done_busy", Busy_o, 1'b0);
          check_eq("lock", AvalonLock_o, 1'b0);
          if (exp_h == 0) check_eq("h0_latency", (cyc - start_cyc) <= 2, 1'b1);
          frame_active = 1'b0;
          done_seen = 1'b1;
        end
        prev_last = ShareValid_o && ShareLast_o;
        Halt_i = halt_force || (rand_halt && ($urandom_range(0, 3) == 0));
      end
    end
  end

  task automatic start_frame(input logic [63:0] b, input logic [15:0] s, input logic [8:0] h);
    @(negedge clk);
    Start_i    = 1'b1;
    BaseAddr_i = b;
    Stride_i   = s;
    Height_i   = h;
    exp_base   = (b == 64'd0) ? DEF_BASE : b;
    exp_stride = s;
    exp_h      = int'(h);
    rd_idx     = 0;
    em_idx     = 0;
    start_cyc  = cyc;
    done_seen  = 1'b0;
    frame_active = 1'b1;
    @(negedge clk);
    Start_i    = 1'b0;
    BaseAddr_i = {$urandom, $urandom};
    Stride_i   = 16'($urandom);
    Height_i   = 9'($urandom);
    if (h != 9'd0) check_eq("busy_on", Busy_o, 1'b1);
  endtask

  task automatic wait_done(input bit fin_start);
    int n;
    n = 0;
    while (!done_seen && n < 5000) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    check_eq("done_seen", done_seen, 1'b1);
    if (!done_seen) frame_active = 1'b0;
    if (fin_start && done_seen) begin
      Start_i    = 1'b1;
      Height_i   = 9'd5;
      BaseAddr_i = 64'h2000;
      @(negedge clk);
      #1;
      Start_i = 1'b0;
      check_eq("fin_start_ignored", {Busy_o, AvalonRead_o}, 2'b00);
    end
  endtask

  task automatic run_frame(input logic [63:0] b, input logic [15:0] s, input logic [8:0] h);
    start_frame(b, s, h);
    wait_done(1'b0);
  endtask

  initial begin : stimulus
    int n;
    logic [8:0] h;
    rst = 1'b1;
    Start_i = 1'b0;
    BaseAddr_i = 64'd0;
    Stride_i = 16'd0;
    Height_i = 9'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {Busy_o, Done_o, AvalonRead_o, AvalonLock_o, ShareValid_o, ShareFirst_o, ShareLast_o}, 7'd0);
    check_eq("rst_line", ShareLine_o, 512'd0);
    check_eq("rst_addr", AvalonAddr_o, 64'd0);
    rst = 1'b0;

    run_frame(64'h1000, 16'd64, 9'd4);
    run_frame(64'h3000, 16'd64, 9'd1);
    run_frame(64'h5000, 16'd64, 9'd0);

    stall_len = 5;
    run_frame(64'h7000, 16'd200, 9'd3);
    stall_len = 0;

    start_frame(64'h10_0000, 16'd512, 9'd8);
    n = 0;
    while (em_idx < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    halt_force = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("halt_buffered", rd_idx - em_idx, 4);
    check_eq("halt_no_read", AvalonRead_o, 1'b0);
    halt_force = 1'b0;
    wait_done(1'b0);

    stall_len = 1;
    start_frame(64'h4000, 16'd256, 9'd6);
    n = 0;
    while (rd_idx < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    check_eq("rst_pre_reads", rd_idx, 2);
    #2;
    rst = 1'b1;
    frame_active = 1'b0;
    #1;
    check_eq("rst_mid_ctl", {Busy_o, Done_o, AvalonRead_o, ShareValid_o, ShareFirst_o, ShareLast_o}, 6'd0);
    check_eq("rst_mid_line", ShareLine_o, 512'd0);
    repeat (4) @(negedge clk);
    check_eq("rst_no_done", done_seen, 1'b0);
    rst = 1'b0;
    stall_len = 0;
    run_frame(64'h4000, 16'd256, 9'd6);

    run_frame(64'd0, 16'd128, 9'd3);
    run_frame(64'hFFFF_FFFF_FFFF_FF80, 16'd64, 9'd5);

    rand_stall = 1'b1;
    rand_halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      h = 9'($urandom_range(1, 40));
      start_frame({$urandom, $urandom}, 16'($urandom), h);
      if (h >= 9'd8) begin
        @(negedge clk);
        @(negedge clk);
        Start_i    = 1'b1;
        Height_i   = 9'd3;
        BaseAddr_i = {$urandom, $urandom};
        @(negedge clk);
        Start_i = 1'b0;
      end
      wait_done(i[0]);
    end
    rand_stall = 1'b0;
    rand_halt = 1'b0;

    run_frame(64'h1234_5678_0000_0000, 16'hFFFF, 9'd511);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fmap_line_reader.md
Name: fmap_line_reader

Overview:
- Upstream feeder of the convolution cores' shared input-feature bus.
- Fetches Height_i consecutive 512-bit feature-map lines from memory over an Avalon-MM read master.
- Buffers the lines in a small FIFO and broadcasts them on the ShareValid/ShareLine/ShareFirst/ShareLast bus consumed by every core's IFBuffer.
- Honours the cores' Halt backpressure so no line is lost.

Parameters:
- FifoDepth, 4, line-FIFO depth in 512-bit entries; power of two, minimum 2.
- DefaultBase, 64'h0, base address used when BaseAddr_i is 0.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- Start_i  in  1  one-cycle pulse that launches a frame; ignored while Busy_o=1
- BaseAddr_i  in  64  byte address of line 0; sampled on accepted Start_i
- Stride_i  in  16  byte distance between lines; sampled on accepted Start_i
- Height_i  in  9  number of lines; sampled on accepted Start_i
- Busy_o  out  1  high from the accepted Start_i until Done_o
- Done_o  out  1  one-cycle pulse once the frame is fully emitted
- AvalonAddr_o  out  64  read address
- AvalonRead_o  out  1  read request
- AvalonReadData_i  in  512  read data
- AvalonWaitReq_i  in  1  slave stall
- AvalonLock_o  out  1  tied 0
- ShareValid_o  out  1  share-line valid
- ShareLine_o  out  512  share-line data
- ShareFirst_o  out  1  marks line 0 of the frame
- ShareLast_o  out  1  marks line Height-1 of the frame
- Halt_i  in  1  OR of core halts; consumer stall

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to IDLE and the FIFO is flushed.
  - All outputs are 0; ShareLine_o is 0.
  - Reset mid-frame aborts the frame: no Done_o, no further reads.
- FSM states and transitions:
  - IDLE: on Start_i, latch the operands, clear IssueCnt and EmitCnt, set Busy_o.
    - If Height_i==0, go to FIN immediately with no reads.
    - Otherwise go to READ.
  - READ: AvalonRead_o=1 whenever FIFO occupancy < FifoDepth.
    - AvalonAddr_o = Base + IssueCnt*Stride, computed as a 64-bit running sum with no multiplier.
    - A read completes in a cycle where AvalonRead_o=1 and AvalonWaitReq_i=0; in that cycle AvalonReadData_i is pushed into the FIFO and IssueCnt increments.
    - AvalonRead_o and AvalonAddr_o stay stable while AvalonWaitReq_i=1.
    - After the push with IssueCnt==Height-1, go to DRAIN.
  - DRAIN: no reads. When EmitCnt==Height, go to FIN.
  - FIN: Done_o=1 for one cycle, Busy_o drops the same cycle, next state IDLE.
- Output stage (registered, one-cycle latency):
  - A pop happens in any cycle where the FIFO is non-empty and Halt_i=0.
  - The next cycle: ShareValid_o=1 with the popped line; ShareFirst_o=(EmitCnt==0); ShareLast_o=(EmitCnt==Height-1). EmitCnt then increments.
  - In cycles without a pop, ShareValid_o, ShareFirst_o and ShareLast_o are 0 and ShareLine_o holds its last value.
  - Height==1: ShareFirst_o and ShareLast_o assert together.
- FIFO boundaries:
  - Simultaneous push and pop when full is allowed; occupancy is unchanged.
  - Pop on empty never occurs.
  - Push is gated, so overflow is impossible.
- Start_i while Busy_o=1 is ignored. A Start_i in the FIN cycle is also ignored.
- Counters are 9 bits; Height 511 is the maximum. The address sum wraps modulo 2^64.
- Done_o asserts exactly one cycle after the cycle carrying ShareLast_o.

Decomposition:
- Shared package fmap_pkg:
  - LINE_W=512, ADDR_W=64, HEIGHT_W=9
  - FSM state enum {IDLE, READ, DRAIN, FIN}
- One sub-module: line_fifo, parameterised width and depth.
  - Ports: clk, rst, push, push_data, pop, pop_data, full, empty, count.
  - Show-ahead read.

Test Plan:
- Base=0x1000, Stride=64, Height=4, no waitreq, Halt=0:
  - Reads go to 0x1000/0x1040/0x1080/0x10C0.
  - Four ShareValid pulses with data in order; First on line 0, Last on line 3.
  - Done one cycle after Last.
- Height=1:
  - Exactly one read.
  - The single ShareValid cycle has First=Last=1.
  - Done follows; Busy back to 0.
- Height=0:
  - No AvalonRead_o.
  - Done pulses within 2 cycles of Start_i.
- AvalonWaitReq_i held high 5 cycles on every read, Height=3:
  - Address and Read are stable during the stalls.
  - Exactly 3 pushes; output order intact.
- Halt_i=1 for 20 cycles mid-frame, Height=8:
  - Reads stop after FifoDepth lines are buffered.
  - No ShareValid while halted.
  - After release, all 8 lines are delivered in order with no loss or duplication.
- rst asserted during READ after 2 of 6 lines:
  - Outputs go to 0 immediately and no Done pulse appears.
  - A new Start_i afterwards runs a clean frame with First on its line 0.
